instr_fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core. Holds the PC, issues word requests to instruction memory over a valid/ready channel, and buffers returned instructions in a small in-order FIFO. It presents the head instruction and its decoded fields `op`, `funct3` and `funct7_5` directly to `Control_unit`. It consumes the control unit's `PCSrc`/`JALR_Src` to redirect the PC and flush stale instructions.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/instr_fetch_unit.sv | 109 ++++++++++
 tb/tb_instr_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I opcodes, instruction field layout and default reset PC
package riscv_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous circular FIFO with flush; head is read combinationally
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // pointer and occupancy next state; flush wins over push/pop
    always_comb begin
        wr_d  = flush_i ? '0 : push_i ? inc(wr_q) : wr_q;
        rd_d  = flush_i ? '0 : pop_i ? inc(rd_q) : rd_q;
        cnt_d = flush_i ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
    end

    // pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // storage write; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage (PC, imem requests, instruction FIFO, redirect/flush)
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirect target raises misalign_err and halts fetch.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7_5,
    input  logic        PCSrc,
    input  logic        JALR_Src,
    input  logic [31:0] redirect_target,
    output logic        misalign_err
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic          run_q, halt;
    logic [31:0]   pc_q, pc_d, tgt, rsp_pc;
    logic [CW-1:0] drop_q, drop_d, outstanding, count;
    logic [63:0]   head;
    logic          pop, redirect, req_fire, push;

    assign tgt            = {redirect_target[31:1], redirect_target[0] & ~JALR_Src};
    assign imem_req_valid = run_q & ~halt & (({1'b0, outstanding} + {1'b0, count}) < (CW + 1)'(BUF_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign instr_valid    = count != '0;
    assign pop            = instr_valid & instr_ready;
    assign redirect       = pop & (PCSrc | JALR_Src);
    assign push           = imem_rsp_valid & (drop_q == '0);
    assign instr          = instr_valid ? head[31:0] : '0;
    assign instr_pc       = instr_valid ? head[63:32] : '0;
    assign op             = instr[6:0];
    assign funct3         = instr[14:12];
    assign funct7_5       = instr[30];

    // PC and stale-response bookkeeping; redirect overrides the sequential increment
    always_comb begin
        pc_d   = redirect ? (tgt & 32'hFFFF_FFFC) : req_fire ? pc_q + 32'd4 : pc_q;
        drop_d = redirect ? outstanding + CW'(req_fire) - CW'(imem_rsp_valid)
               : (imem_rsp_valid && drop_q != '0) ? drop_q - 1'b1 : drop_q;
    end

    // run starts one clock after reset release; PC and drop counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            run_q  <= 1'b1;
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic err_q;

    // sticky misaligned-redirect error, which also stops further fetching
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else if (redirect && tgt[1:0] != 2'b00) err_q <= 1'b1;
    end

    assign halt         = err_q;
    assign misalign_err = err_q;
`else
    assign halt         = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // PCs of in-flight requests, in issue order; its occupancy is the outstanding count
    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(32)) u_pcq (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (1'b0),
        .push_i  (req_fire),
        .wdata_i (pc_q),
        .pop_i   (imem_rsp_valid),
        .rdata_o (rsp_pc),
        .count_o (outstanding)
    );

    // returned instructions with their PCs, flushed on redirect
    fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(64)) u_ibuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect),
        .push_i  (push),
        .wdata_i ({rsp_pc, imem_rsp_data}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench for instr_fetch_unit with a queued 1-cycle memory model
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        PCSrc, JALR_Src;
    logic [31:0] redirect_target;
    logic        misalign_err;
    logic        rsp_en;
    logic [31:0] mq[$];
    int          vecs = 0;
    int          errs = 0;

    instr_fetch_unit #(.RESET_PC(32'h100), .BUF_DEPTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .op              (op),
        .funct3          (funct3),
        .funct7_5        (funct7_5),
        .PCSrc           (PCSrc),
        .JALR_Src        (JALR_Src),
        .redirect_target (redirect_target),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    // memory: word at address a is a ^ 32'h4000_7013; responses in order, held while rsp_en is 0
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);
            if (rsp_en && mq.size() > 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mq.pop_front() ^ 32'h4000_7013;
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] exp_pc;
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b0;
        PCSrc = 1'b0;
        JALR_Src = 1'b0;
        redirect_target = '0;
        rsp_en = 1'b1;
        #2 rst_n = 1'b0;
        step;
        step;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_misalign", misalign_err, 0);
        chk("rst_addr", imem_req_addr, 32'h100);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_op", op, 0);
        chk("rst_funct3", funct3, 0);
        chk("rst_funct7_5", funct7_5, 0);
        rst_n = 1'b1;
        chk("first_clk_no_req", imem_req_valid, 0);
        step;
        chk("req0_valid", imem_req_valid, 1);
        chk("req0_addr", imem_req_addr, 32'h100);
        step;
        chk("req1_valid", imem_req_valid, 1);
        chk("req1_addr", imem_req_addr, 32'h104);
        chk("no_instr_yet", instr_valid, 0);
        step;
        chk("full_stall", imem_req_valid, 0);
        chk("first_instr_valid", instr_valid, 1);
        chk("first_instr_pc", instr_pc, 32'h100);
        chk("first_instr", instr, 32'h4000_7113);
        chk("first_op", op, OP_IMM);
        step;
        step;
        step;
        chk("stall_hold", imem_req_valid, 0);
        chk("stall_head_pc", instr_pc, 32'h100);
        instr_ready = 1'b1;
        step;
        instr_ready = 1'b0;
        chk("one_pop_req", imem_req_valid, 1);
        chk("one_pop_addr", imem_req_addr, 32'h108);
        chk("one_pop_head", instr_pc, 32'h104);
        step;
        chk("one_req_only_a", imem_req_valid, 0);
        step;
        chk("one_req_only_b", imem_req_valid, 0);
        instr_ready = 1'b1;
        step;
        instr_ready = 1'b0;
        rsp_en = 1'b0;
        chk("pre_jal_addr", imem_req_addr, 32'h10C);
        chk("pre_jal_head", instr_pc, 32'h108);
        step;
        chk("inflight_stall", imem_req_valid, 0);
        instr_ready = 1'b1;
        PCSrc = 1'b1;
        redirect_target = 32'h200;
        step;
        PCSrc = 1'b0;
        instr_ready = 1'b0;
        rsp_en = 1'b1;
        chk("jal_addr", imem_req_addr, 32'h200);
        chk("jal_req_valid", imem_req_valid, 1);
        chk("jal_flush", instr_valid, 0);
        chk("jal_empty_instr", instr, 0);
        chk("jal_empty_pc", instr_pc, 0);
        step;
        chk("jal_drop_a", instr_valid, 0);
        step;
        chk("jal_drop_b", instr_valid, 0);
        chk("jal_next_addr", imem_req_addr, 32'h204);
        step;
        chk("jal_deliver_valid", instr_valid, 1);
        chk("jal_deliver_pc", instr_pc, 32'h200);
        chk("jal_deliver_instr", instr, 32'h4000_7213);
        instr_ready = 1'b1;
        JALR_Src = 1'b1;
        redirect_target = 32'h301;
        step;
        JALR_Src = 1'b0;
        redirect_target = '0;
        chk("jalr_addr", imem_req_addr, 32'h300);
        chk("jalr_req_valid", imem_req_valid, 1);
        chk("jalr_flush", instr_valid, 0);
        chk("jalr_misalign", misalign_err, 0);
        step;
        step;
        chk("jalr_deliver_pc", instr_pc, 32'h300);
        chk("jalr_instr", instr, 32'h4000_7313);
        chk("jalr_funct3", funct3, 3'd7);
        chk("jalr_funct7_5", funct7_5, 1);
        PCSrc = 1'b1;
        redirect_target = 32'h402;
        step;
        PCSrc = 1'b0;
        instr_ready = 1'b0;
        chk("br402_flush", instr_valid, 0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("br402_misalign", misalign_err, 1);
        chk("br402_halt", imem_req_valid, 0);
        step;
        step;
        chk("halt_hold", imem_req_valid, 0);
        chk("halt_empty", instr_valid, 0);
        chk("misalign_sticky", misalign_err, 1);
`else
        chk("br402_misalign", misalign_err, 0);
        chk("br402_req_valid", imem_req_valid, 1);
        chk("br402_addr", imem_req_addr, 32'h400);
        step;
        step;
        chk("br402_deliver_pc", instr_pc, 32'h400);
        chk("br402_instr", instr, 32'h4000_7413);
`endif
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", imem_req_valid, 0);
        chk("async_rst_valid", instr_valid, 0);
        chk("async_rst_misalign", misalign_err, 0);
        chk("async_rst_addr", imem_req_addr, 32'h100);
        step;
        rst_n = 1'b1;
        step;
        chk("restart_req", imem_req_valid, 1);
        chk("restart_addr", imem_req_addr, 32'h100);
        n = 0;
        exp_pc = 32'h100;
        for (int i = 0; i < 100; i++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            if (instr_valid && instr_ready) begin
                chk("seq_pc", instr_pc, exp_pc);
                chk("seq_instr", instr, exp_pc ^ 32'h4000_7013);
                exp_pc += 32'd4;
                n++;
            end
            step;
        end
        chk("seq_progress", 32'(n >= 10), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
